// File: rtl/fifo_reader.sv
// Drains a requested number of words from a FIFO into a ready/valid stream
// through a 2-entry skid buffer, with a one-cycle done pulse per request.
module fifo_reader #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    len,
    output logic          busy,
    output logic          done,
    output logic          fifo_re,
    input  logic [DW-1:0] fifo_rdata,
    input  logic          fifo_empty,
    input  logic          fifo_wr_act,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [7:0]    rd_count
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    rd_count_q, rd_count_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] buf0_q, buf0_d;
    logic [DW-1:0] buf1_q, buf1_d;
    logic          start_ok, rd_acc, push, pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            rd_count_q <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            rd_count_q <= rd_count_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len != 8'd0) ? RUN : DONE;
            RUN:     if (rem_q == 8'd0) state_d = FLUSH;
            FLUSH:   if (!inflight_q && cnt_q == 2'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // fifo_re is gated by rst so a read can never be accepted while aborting.
    always_comb begin
        busy      = (state_q == RUN) || (state_q == FLUSH);
        done      = (state_q == DONE);
        fifo_re   = !rst && (state_q == RUN) && (rem_q != 8'd0) && !fifo_empty &&
                    (({1'b0, inflight_q} + cnt_q) < 2'd2);
        out_valid = (cnt_q != 2'd0);
        out_data  = buf0_q;
        rd_count  = rd_count_q;
    end

    always_comb begin
        start_ok   = (state_q == IDLE) && start;
        rd_acc     = fifo_re && !fifo_empty && !fifo_wr_act;
        push       = inflight_q;
        pop        = out_valid && out_ready;
        inflight_d = rd_acc;

        rem_d = rem_q;
        if (start_ok)    rem_d = len;
        else if (rd_acc) rem_d = rem_q - 8'd1;

        rd_count_d = rd_count_q;
        if (start_ok)                        rd_count_d = '0;
        else if (pop && rd_count_q != 8'hFF) rd_count_d = rd_count_q + 8'd1;

        // buf0 is always the oldest entry; a pop shifts buf1 down.
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        if (push && pop) begin
            if (cnt_q == 2'd1) begin
                buf0_d = fifo_rdata;
            end else begin
                buf0_d = buf1_q;
                buf1_d = fifo_rdata;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) buf0_d = fifo_rdata;
            else               buf1_d = fifo_rdata;
            cnt_d = cnt_q + 2'd1;
        end else if (pop) begin
            buf0_d = buf1_q;
            cnt_d  = cnt_q - 2'd1;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized directed bench: the bench acts as the FIFO and checks the output
// stream against the FIFO's word history in order.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst, start, fifo_re, fifo_empty, fifo_wr_act;
    logic       busy, done, out_valid, out_ready;
    logic [7:0] len_i, fifo_rdata, out_data, rd_count;

    fifo_reader #(.DW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len_i), .busy(busy), .done(done),
        .fifo_re(fifo_re), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .fifo_wr_act(fifo_wr_act), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;
    logic [7:0] fq[$];
    logic [7:0] hist[$];
    int pops = 0, base = 0, outs = 0, req_reads = 0, done_seen = 0, re_seen = 0;
    int rdy_pct = 100, wr_pct = 0;
    bit in_req = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fq.push_back(w);
        hist.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample before the edge, then act as the FIFO after it.
    task automatic cycle();
        logic       acc, pop, wr;
        logic [7:0] e;
        int         idx;
        #2;
        acc = fifo_re && !fifo_empty && !fifo_wr_act;
        pop = out_valid && out_ready;
        wr  = fifo_wr_act;
        if (fifo_re) re_seen++;
        if (done) done_seen++;
        if (pop) begin
            idx = base + outs;
            e = 'x;
            if (idx < hist.size()) e = hist[idx];
            chk("out_data", out_data, e);
            outs++;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            fifo_rdata = fq.pop_front();
            pops++;
            req_reads++;
        end else begin
            fifo_rdata = 8'($urandom);
        end
        if (wr) push_word(8'($urandom));
        fifo_empty  = (fq.size() == 0);
        out_ready   = ($urandom_range(99) < rdy_pct);
        fifo_wr_act = ($urandom_range(99) < wr_pct);
        if (in_req) chk("rd_count_run", rd_count, (outs > 255) ? 255 : outs);
    endtask

    task automatic begin_req(input int L, input int rdy, input int wr);
        rdy_pct     = rdy;
        wr_pct      = wr;
        out_ready   = ($urandom_range(99) < rdy_pct);
        fifo_wr_act = ($urandom_range(99) < wr_pct);
        base = pops; outs = 0; req_reads = 0; done_seen = 0; re_seen = 0;
        start = 1'b1;
        len_i = 8'(L);
        cycle();
        start = 1'b0;
        in_req = 1;
    endtask

    task automatic wait_done(input int inj, input int budget);
        int n = 0;
        while (done_seen == 0 && n < budget) begin
            start = (n == inj);
            if (n == inj) len_i = 8'd1;
            cycle();
            n++;
        end
        start = 1'b0;
        chk("done_timeout", done_seen, 1);
    endtask

    task automatic end_req(input int L);
        cycle();
        cycle();
        chk("done_once", done_seen, 1);
        chk("outs", outs, L);
        chk("reads", req_reads, L);
        chk("rd_count_end", rd_count, (L > 255) ? 255 : L);
        chk("busy_end", busy, 0);
        in_req = 0;
    endtask

    initial begin
        int L;
        rst = 1'b1; start = 1'b0; len_i = '0; out_ready = 1'b0;
        fifo_wr_act = 1'b0; fifo_rdata = '0; fifo_empty = 1'b1;
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        cycle(); cycle();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fifo_re", fifo_re, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_out_data", out_data, 0);

        // Preloaded 11/22/33, always ready.
        begin_req(3, 100, 0);
        wait_done(-1, 50);
        end_req(3);
        chk("empty_end", fifo_empty, 1);

        // len=0: done with no reads.
        begin_req(0, 100, 0);
        wait_done(-1, 3);
        end_req(0);
        chk("len0_re", re_seen, 0);

        // Back-pressure: at most two reads while stalled, first word held.
        for (int i = 0; i < 8; i++) push_word(8'($urandom));
        begin_req(4, 0, 0);
        for (int i = 0; i < 10; i++) cycle();
        chk("hold_reads", (req_reads <= 2), 1);
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hist[base]);
        rdy_pct = 100; out_ready = 1'b1;
        wait_done(-1, 60);
        end_req(4);

        // Writes colliding with reads and an empty FIFO stalling the request.
        push_word(8'($urandom));
        begin_req(10, 70, 50);
        wait_done(-1, 400);
        end_req(10);

        // start while busy is ignored.
        for (int i = 0; i < 6; i++) push_word(8'($urandom));
        begin_req(6, 100, 0);
        wait_done(3, 100);
        end_req(6);

        // Abort after two words, then a fresh len=1 request.
        for (int i = 0; i < 6; i++) push_word(8'($urandom));
        begin_req(5, 100, 0);
        for (int n = 0; n < 50 && outs < 2; n++) cycle();
        in_req = 0;
        done_seen = 0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_fifo_re", fifo_re, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_rd_count", rd_count, 0);
        chk("abort_out_data", out_data, 0);
        cycle(); cycle(); cycle();
        chk("abort_no_done", done_seen, 0);
        begin_req(1, 100, 0);
        wait_done(-1, 50);
        end_req(1);

        // Random requests.
        for (int k = 0; k < 4; k++) begin
            L = $urandom_range(20, 1);
            for (int i = 0; i < L; i++) push_word(8'($urandom));
            begin_req(L, $urandom_range(100, 30), $urandom_range(40, 0));
            wait_done(-1, 600);
            end_req(L);
        end

        // Maximum length.
        for (int i = 0; i < 255; i++) push_word(8'($urandom));
        begin_req(255, 100, 20);
        wait_done(-1, 3000);
        end_req(255);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
